// File: rtl/csr_mmio_bridge_pkg.sv
// Shared definitions for the CSR MMIO bridge.
//   CSR_SPI_OFF  : word offset of the SPI data register (accesses are guarded)
//   CSR_WIN_BITS : log2 of the CSR window size in bytes
//   CSR_TAG_W    : request/result tag width carried in the result pipeline
//   csr_stage_t  : one result-pipeline entry {valid, isStore, err, tag}
package csr_mmio_bridge_pkg;

  localparam logic [6:0] CSR_SPI_OFF  = 7'd4;
  localparam int         CSR_WIN_BITS = 9;
  localparam int         CSR_TAG_W    = 6;
  localparam int         CSR_STAGES   = 4;

  typedef enum logic {IDLE, SPI_WAIT} csr_state_t;

  typedef struct packed {
    logic                 valid;
    logic                 isStore;
    logic                 err;
    logic [CSR_TAG_W-1:0] tag;
  } csr_stage_t;

  // Flush kills loads only; store acks must still come back.
  function automatic csr_stage_t csr_kill(input csr_stage_t s, input logic flush);
    csr_stage_t r;
    r = s;
    if (flush && !s.isStore) r.valid = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/csr_mmio_bridge.sv
// CSR MMIO bridge: load/store unit MMIO port -> control-register file.
// Ports:
//   clk, rst (async, active-low)
//   IN_flush                        : kill in-flight load results
//   IN_valid/OUT_ready              : request handshake (one per cycle)
//   IN_isStore/IN_addr/IN_data/IN_wmask/IN_tag : request fields
//   OUT_we/OUT_wm/OUT_writeAddr/OUT_data       : reg-file write port (we active-low)
//   OUT_re/OUT_readAddr/IN_csrData             : reg-file read port (re active-low)
//   IN_IO_busy                      : SPI shift in progress
//   OUT_resValid/OUT_resTag/OUT_resData/OUT_resErr : result, fixed latency 4
module csr_mmio_bridge
  import csr_mmio_bridge_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'hFFFFFE00,
  parameter int          TAG_W = CSR_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_flush,
  input  logic             IN_valid,
  output logic             OUT_ready,
  input  logic             IN_isStore,
  input  logic [31:0]      IN_addr,
  input  logic [31:0]      IN_data,
  input  logic [3:0]       IN_wmask,
  input  logic [TAG_W-1:0] IN_tag,
  output logic             OUT_we,
  output logic [3:0]       OUT_wm,
  output logic [6:0]       OUT_writeAddr,
  output logic [31:0]      OUT_data,
  output logic             OUT_re,
  output logic [6:0]       OUT_readAddr,
  input  logic [31:0]      IN_csrData,
  input  logic             IN_IO_busy,
  output logic             OUT_resValid,
  output logic [TAG_W-1:0] OUT_resTag,
  output logic [31:0]      OUT_resData,
  output logic             OUT_resErr
);

  // ---------------- decode ----------------
  logic       hit, spi_hit, acc;
  logic [6:0] off;
  logic       unused_addr_lsb;

  assign hit     = IN_addr[31:CSR_WIN_BITS] == BASE[31:CSR_WIN_BITS];
  assign off     = IN_addr[CSR_WIN_BITS-1:2];
  assign spi_hit = hit && (off == CSR_SPI_OFF);
  assign acc     = IN_valid && OUT_ready;
  assign unused_addr_lsb = ^IN_addr[1:0];

  // ---------------- SPI guard FSM ----------------
  csr_state_t state, state_nxt;
  logic [1:0] guard, guard_nxt;
  logic       spi_clear;

  // Exit condition is evaluated combinationally so the very cycle busy drops
  // can already accept the next SPI access.
  assign spi_clear = (guard == 2'd0) && !IN_IO_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      guard <= 2'd0;
    end else begin
      state <= state_nxt;
      guard <= guard_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    guard_nxt = guard;
    case (state)
      IDLE: ;
      SPI_WAIT: begin
        if (guard != 2'd0) guard_nxt = guard - 2'd1;
        if (spi_clear)     state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Guard covers the lag between the write and IN_IO_busy rising.
    if (acc && IN_isStore && spi_hit) begin
      state_nxt = SPI_WAIT;
      guard_nxt = 2'd2;
    end
  end

  always_comb begin
    OUT_ready = 1'b1;
    if (state == SPI_WAIT && spi_hit && !spi_clear) OUT_ready = 1'b0;
  end

  // ---------------- S1: register-file port ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      OUT_re        <= 1'b1;
      OUT_we        <= 1'b1;
      OUT_readAddr  <= '0;
      OUT_writeAddr <= '0;
      OUT_wm        <= '0;
      OUT_data      <= '0;
    end else begin
      // Flush is deliberately ignored here: a killed read is harmless.
      OUT_re <= !(acc && hit && !IN_isStore);
      OUT_we <= !(acc && hit &&  IN_isStore);
      if (acc && hit && !IN_isStore) OUT_readAddr <= off;
      if (acc && hit && IN_isStore) begin
        OUT_writeAddr <= off;
        OUT_wm        <= IN_wmask;
        OUT_data      <= IN_data;
      end
    end
  end

  // ---------------- result pipeline ----------------
  csr_stage_t pipe [CSR_STAGES];
  csr_stage_t s_in, s2_nxt;
  logic [31:0] res_data;
  logic        unused_last_st;

  always_comb begin
    s_in         = '0;
    s_in.valid   = acc;
    s_in.isStore = IN_isStore;
    s_in.err     = !hit;
    s_in.tag     = IN_tag;
  end

  assign s2_nxt = csr_kill(pipe[2], IN_flush);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CSR_STAGES; i++) pipe[i] <= '0;
      res_data <= '0;
    end else begin
      pipe[0] <= csr_kill(s_in, IN_flush);
      for (int i = 1; i < CSR_STAGES; i++) pipe[i] <= csr_kill(pipe[i-1], IN_flush);
      // Reg-file data for the request in stage 2 is valid at this edge.
      res_data <= (s2_nxt.valid && !s2_nxt.isStore && !s2_nxt.err) ? IN_csrData : 32'd0;
    end
  end

  assign OUT_resValid   = pipe[CSR_STAGES-1].valid;
  assign OUT_resTag     = pipe[CSR_STAGES-1].tag;
  assign OUT_resErr     = pipe[CSR_STAGES-1].valid & pipe[CSR_STAGES-1].err;
  assign OUT_resData    = res_data;
  assign unused_last_st = pipe[CSR_STAGES-1].isStore;

endmodule
